// File: rtl/pipe_packet_fifo_pkg.sv
// Shared types and sizing helpers for the packet-aware pipe FIFO.
package pipe_packet_fifo_pkg;

    localparam int unsigned PIPE_WIDTH_DEFAULT = 32;
    localparam int unsigned PIPE_DEPTH_DEFAULT = 16;

    typedef enum logic {
        PIPE_CUT_THROUGH = 1'b0,
        PIPE_STORE_FWD   = 1'b1
    } pipe_mode_e;

    // Occupancy and packet counters must be able to hold the value DEPTH itself.
    function automatic int unsigned pipe_cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pipe_packet_fifo_if.sv
// Producer (enq) and consumer (deq) handshake bundle of the packet FIFO.
interface pipe_packet_fifo_if
    import pipe_packet_fifo_pkg::*;
#(
    parameter int WIDTH = PIPE_WIDTH_DEFAULT
);
    // Handshake: a beat moves only on a cycle where ENA and RDY are both high.
    // RDY depends on registered state only, and an ENA raised while RDY=0 is ignored.
    logic             enq__ENA;
    logic [WIDTH-1:0] enq__v;
    logic             enq__last;
    logic             enq__RDY;

    logic             deq__ENA;
    logic             deq__RDY;
    logic [WIDTH-1:0] first;
    logic             first__RDY;
    logic             last;
    logic             last__RDY;

    modport master (
        output enq__ENA, enq__v, enq__last, deq__ENA,
        input  enq__RDY, deq__RDY, first, first__RDY, last, last__RDY
    );

    modport slave (
        input  enq__ENA, enq__v, enq__last, deq__ENA,
        output enq__RDY, deq__RDY, first, first__RDY, last, last__RDY
    );
endinterface

// File: rtl/pipe_packet_fifo_ram.sv
// Beat storage: single write port, asynchronous read port, contents not reset.
module pipe_fifo_ram #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/pipe_packet_fifo.sv
// Packet-aware FIFO with per-beat last tracking and cut-through or
// store-and-forward release, including a forced release for oversize packets.
module pipe_packet_fifo
    import pipe_packet_fifo_pkg::*;
#(
    parameter int WIDTH     = PIPE_WIDTH_DEFAULT,
    parameter int DEPTH     = PIPE_DEPTH_DEFAULT,
    parameter int STORE_FWD = 1
) (
    input  logic                         CLK,
    input  logic                         nRST,
    pipe_packet_fifo_if.slave            io,
    output logic [pipe_cnt_w(DEPTH)-1:0] pkt_count,
    output logic                         oversize,
    output logic                         dbg_release
);
    localparam int         AW   = $clog2(DEPTH);
    localparam int         CW   = pipe_cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam pipe_mode_e MODE = (STORE_FWD != 0) ? PIPE_STORE_FWD : PIPE_CUT_THROUGH;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } pipe_beat_t;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [CW-1:0] pkt_q,    pkt_d;
    logic          rel_q,    rel_d;
    logic          oversize_q, oversize_d;

    pipe_beat_t wr_beat;
    pipe_beat_t rd_beat;
    logic       enq_rdy, deq_rdy, occupied;
    logic       enq_fire, deq_fire;
    logic       pkt_inc, pkt_dec;
    logic       force_rel;

    assign wr_beat = '{data: io.enq__v, last: io.enq__last};

    pipe_fifo_ram #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_ram (
        .CLK   (CLK),
        .we    (enq_fire),
        .waddr (wr_ptr_q),
        .wdata (wr_beat),
        .raddr (rd_ptr_q),
        .rdata (rd_beat)
    );

    always_comb begin
        occupied  = (count_q != '0);
        enq_rdy   = (count_q != FULL);
        deq_rdy   = occupied && ((MODE == PIPE_CUT_THROUGH) || (pkt_q != '0) || rel_q);
        enq_fire  = io.enq__ENA && enq_rdy;
        deq_fire  = io.deq__ENA && deq_rdy;
        pkt_inc   = enq_fire && io.enq__last;
        pkt_dec   = deq_fire && rd_beat.last;
        // Full with no complete packet inside can never drain on its own.
        force_rel = (MODE == PIPE_STORE_FWD) && (count_q == FULL) && (pkt_q == '0);

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        pkt_d      = pkt_q;
        rel_d      = rel_q;
        oversize_d = oversize_q | force_rel;

        if (enq_fire) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (deq_fire) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({enq_fire, deq_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case ({pkt_inc, pkt_dec})
            2'b10:   pkt_d = pkt_q + CW'(1);
            2'b01:   pkt_d = pkt_q - CW'(1);
            default: pkt_d = pkt_q;
        endcase

        if (force_rel) begin
            rel_d = 1'b1;
        end else if (pkt_dec) begin
            rel_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pkt_q      <= '0;
            rel_q      <= 1'b0;
            oversize_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pkt_q      <= pkt_d;
            rel_q      <= rel_d;
            oversize_q <= oversize_d;
        end
    end

    // Head outputs read as zero while empty so stale RAM contents never leak out.
    assign io.enq__RDY   = enq_rdy;
    assign io.deq__RDY   = deq_rdy;
    assign io.first__RDY = deq_rdy;
    assign io.last__RDY  = deq_rdy;
    assign io.first      = occupied ? rd_beat.data : '0;
    assign io.last       = occupied & rd_beat.last;

    assign pkt_count   = pkt_q;
    assign oversize    = oversize_q;
    assign dbg_release = rel_q;
endmodule

// File: tb/tb_pipe_packet_fifo.sv
// Directed bench: a cut-through and a store-and-forward instance, DEPTH=4, WIDTH=32.
module tb_pipe_packet_fifo;
    logic CLK;
    logic nRST;

    int errors = 0;
    int checks = 0;

    logic [32:0] exp_q[$];

    logic        sel;
    logic        enq_ena;
    logic        deq_ena;
    logic        enq_last;
    logic [31:0] enq_data;

    pipe_packet_fifo_if #(.WIDTH(32)) ct_if ();
    pipe_packet_fifo_if #(.WIDTH(32)) sf_if ();

    logic [2:0] ct_pkt, sf_pkt;
    logic       ct_ovs, sf_ovs, ct_rel, sf_rel;

    assign ct_if.enq__ENA  = enq_ena & ~sel;
    assign ct_if.enq__v    = enq_data;
    assign ct_if.enq__last = enq_last;
    assign ct_if.deq__ENA  = deq_ena & ~sel;
    assign sf_if.enq__ENA  = enq_ena & sel;
    assign sf_if.enq__v    = enq_data;
    assign sf_if.enq__last = enq_last;
    assign sf_if.deq__ENA  = deq_ena & sel;

    pipe_packet_fifo #(.WIDTH(32), .DEPTH(4), .STORE_FWD(0)) u_ct (
        .CLK         (CLK),
        .nRST        (nRST),
        .io          (ct_if),
        .pkt_count   (ct_pkt),
        .oversize    (ct_ovs),
        .dbg_release (ct_rel)
    );

    pipe_packet_fifo #(.WIDTH(32), .DEPTH(4), .STORE_FWD(1)) u_sf (
        .CLK         (CLK),
        .nRST        (nRST),
        .io          (sf_if),
        .pkt_count   (sf_pkt),
        .oversize    (sf_ovs),
        .dbg_release (sf_rel)
    );

    logic        m_enq_rdy, m_deq_rdy, m_first_rdy, m_last_rdy, m_last, m_ovs, m_rel;
    logic [31:0] m_first;
    logic [2:0]  m_pkt;

    assign m_enq_rdy   = sel ? sf_if.enq__RDY   : ct_if.enq__RDY;
    assign m_deq_rdy   = sel ? sf_if.deq__RDY   : ct_if.deq__RDY;
    assign m_first_rdy = sel ? sf_if.first__RDY : ct_if.first__RDY;
    assign m_last_rdy  = sel ? sf_if.last__RDY  : ct_if.last__RDY;
    assign m_first     = sel ? sf_if.first      : ct_if.first;
    assign m_last      = sel ? sf_if.last       : ct_if.last;
    assign m_pkt       = sel ? sf_pkt           : ct_pkt;
    assign m_ovs       = sel ? sf_ovs           : ct_ovs;
    assign m_rel       = sel ? sf_rel           : ct_rel;

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
        enq_ena = 1'b0;
        deq_ena = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input logic l);
        check("enq_rdy", m_enq_rdy, 1);
        enq_ena  = 1'b1;
        enq_data = d;
        enq_last = l;
        exp_q.push_back({l, d});
        cycle();
    endtask

    task automatic check_head();
        logic [32:0] e;
        check("deq_rdy", m_deq_rdy, 1);
        check("first_rdy", m_first_rdy, 1);
        check("last_rdy", m_last_rdy, 1);
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("first", m_first, e[31:0]);
            check("last", m_last, e[32]);
        end
    endtask

    task automatic pop();
        check_head();
        deq_ena = 1'b1;
        cycle();
    endtask

    task automatic push_pop(input logic [31:0] d, input logic l);
        check_head();
        check("enq_rdy", m_enq_rdy, 1);
        enq_ena  = 1'b1;
        enq_data = d;
        enq_last = l;
        deq_ena  = 1'b1;
        exp_q.push_back({l, d});
        cycle();
    endtask

    initial begin
        sel      = 1'b0;
        enq_ena  = 1'b0;
        deq_ena  = 1'b0;
        enq_last = 1'b0;
        enq_data = '0;
        nRST     = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        // reset state, both instances
        sel = 1'b0;
        check("rst_ct_deq_rdy", m_deq_rdy, 0);
        check("rst_ct_pkt", m_pkt, 0);
        check("rst_ct_first", m_first, 0);
        sel = 1'b1;
        check("rst_sf_deq_rdy", m_deq_rdy, 0);
        check("rst_sf_pkt", m_pkt, 0);
        check("rst_sf_ovs", m_ovs, 0);
        check("rst_sf_last", m_last, 0);
        nRST = 1'b1;
        cycle();
        check("post_rst_sf_enq_rdy", m_enq_rdy, 1);

        // basic cut-through
        sel = 1'b0;
        check("ct_enq_rdy", m_enq_rdy, 1);
        enq_ena  = 1'b1;
        enq_data = 32'hA1;
        enq_last = 1'b0;
        exp_q.push_back({1'b0, 32'hA1});
        check("ct_rdy_same_cycle", m_deq_rdy, 0);
        cycle();
        check("ct_rdy_next_cycle", m_deq_rdy, 1);
        check("ct_pkt_partial", m_pkt, 0);
        push(32'hA2, 1'b1);
        check("ct_pkt_one", m_pkt, 1);
        pop();
        check("ct_pkt_after_a1", m_pkt, 1);
        pop();
        check("ct_pkt_drained", m_pkt, 0);
        check("ct_empty_rdy", m_deq_rdy, 0);

        // store-and-forward hold
        sel = 1'b1;
        push(32'h10, 1'b0);
        push(32'h11, 1'b0);
        check("sf_hold_rdy", m_deq_rdy, 0);
        check("sf_hold_pkt", m_pkt, 0);
        push(32'h12, 1'b1);
        check("sf_release_rdy", m_deq_rdy, 1);
        check("sf_pkt_one", m_pkt, 1);
        pop();
        pop();
        pop();
        check("sf_drained_rdy", m_deq_rdy, 0);
        check("sf_drained_pkt", m_pkt, 0);

        // full and wrap
        sel = 1'b0;
        for (int i = 1; i <= 4; i++) push(32'(i), 1'b1);
        check("full_enq_rdy", m_enq_rdy, 0);
        check("full_pkt", m_pkt, 4);
        enq_ena  = 1'b1;
        enq_data = 32'h99;
        enq_last = 1'b1;
        cycle();
        check("full_ignored_pkt", m_pkt, 4);
        check("full_ignored_head", m_first, 32'h1);
        pop();
        pop();
        push(32'h5, 1'b1);
        push(32'h6, 1'b1);
        for (int i = 0; i < 4; i++) pop();
        check("wrap_empty", m_deq_rdy, 0);

        // simultaneous enq+deq at occupancy 2
        push(32'h7, 1'b1);
        push(32'h8, 1'b1);
        check("sim_pkt_before", m_pkt, 2);
        push_pop(32'h9, 1'b1);
        check("sim_pkt_after", m_pkt, 2);
        check("sim_enq_rdy", m_enq_rdy, 1);
        pop();
        pop();
        check("sim_occ_two", m_deq_rdy, 0);

        // oversize packet in store-and-forward
        sel = 1'b1;
        for (int i = 0; i < 4; i++) push(32'h20 + 32'(i), 1'b0);
        check("ovs_full", m_enq_rdy, 0);
        check("ovs_blocked", m_deq_rdy, 0);
        check("ovs_rel_not_yet", m_rel, 0);
        check("ovs_pkt_zero", m_pkt, 0);
        cycle();
        check("ovs_rel_set", m_rel, 1);
        check("ovs_flag_set", m_ovs, 1);
        pop();
        pop();
        push(32'h24, 1'b0);
        push(32'h25, 1'b1);
        pop();
        pop();
        pop();
        check("ovs_rel_held", m_rel, 1);
        pop();
        check("ovs_rel_cleared", m_rel, 0);
        check("ovs_flag_sticky", m_ovs, 1);
        check("ovs_drained", m_deq_rdy, 0);
        check("ovs_pkt_end", m_pkt, 0);

        // async reset mid-packet
        push(32'h30, 1'b0);
        push(32'h31, 1'b1);
        push(32'h32, 1'b0);
        check("arst_pre_rdy", m_deq_rdy, 1);
        nRST = 1'b0;
        #1;
        check("arst_deq_rdy", m_deq_rdy, 0);
        check("arst_pkt", m_pkt, 0);
        check("arst_ovs", m_ovs, 0);
        check("arst_last", m_last, 0);
        exp_q.delete();
        cycle();
        nRST = 1'b1;
        cycle();
        check("arst_enq_rdy", m_enq_rdy, 1);
        push(32'h40, 1'b0);
        push(32'h41, 1'b1);
        check("arst_fresh_pkt", m_pkt, 1);
        pop();
        pop();
        check("arst_fresh_done", m_pkt, 0);
        check("arst_fresh_empty", m_deq_rdy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_packet_fifo.md
Name: pipe_packet_fifo

Overview:
- Parametrised packet-aware FIFO between a PipeInLast producer and a PipeOutLast consumer.
- Successor to plain Pipe buffering: adds configurable width and depth, per-beat last tracking, and a selectable cut-through or store-and-forward mode.
- Sits in NOC and DMA paths where a downstream consumer must see whole packets without bubbles.

Parameters:
- WIDTH, 32, data bits per beat (>=1).
- DEPTH, 16, beats of storage; power of 2, >=2.
- STORE_FWD, 1, 1 = store-and-forward (output only once a complete packet is resident); 0 = cut-through.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- nRST  input  1  asynchronous active-low reset.
- enq__ENA  input  1  enqueue strobe; producer asserts only when enq__RDY=1.
- enq$v  input  WIDTH  beat data.
- enq$last  input  1  beat is final beat of packet.
- enq__RDY  output  1  space available.
- deq__ENA  input  1  dequeue strobe; consumer asserts only when deq__RDY=1.
- deq__RDY  output  1  head beat may be dequeued.
- first  output  WIDTH  head beat data.
- first__RDY  output  1  first valid (equals deq__RDY).
- last  output  1  head beat last flag.
- last__RDY  output  1  last valid (equals deq__RDY).
- pkt_count  output  $clog2(DEPTH)+1  complete packets resident.
- oversize  output  1  sticky: store-and-forward release was forced.

Behaviour:
- Reset (async assert, sync-safe deassert): pointers=0, beat count=0, pkt_count=0, release=0, oversize=0. Outputs: enq__RDY=1 once nRST=1, deq__RDY=first__RDY=last__RDY=0, first/last=0 while empty.
- Storage: DEPTH entries of {data,last}. wr_ptr/rd_ptr are log2(DEPTH) bits and wrap naturally. Occupancy counter is $clog2(DEPTH)+1 bits.
- enq fires when enq__ENA && enq__RDY; deq fires when deq__ENA && deq__RDY. Strobes asserted while the matching RDY=0 are ignored and cause no state change.
- enq__RDY = (occupancy != DEPTH), combinational from registered state only. There is no same-cycle pass-through when full, even if deq fires.
- Latency: a beat enqueued in cycle t is visible on first/last and can make deq__RDY high in cycle t+1 at the earliest.
- first/last are driven from the entry at rd_ptr. Their value is undefined-but-stable while deq__RDY=0.
- Simultaneous enq and deq: occupancy is unchanged; both pointers advance.
- pkt_count: +1 on enq with enq$last=1; -1 on deq of a head with last=1; unchanged when both occur.
- Cut-through (STORE_FWD=0): deq__RDY = (occupancy != 0).
- Store-and-forward (STORE_FWD=1): deq__RDY = (occupancy != 0) && (pkt_count != 0 || release).
- Oversize release (STORE_FWD=1 only):
  - Trigger: occupancy==DEPTH && pkt_count==0 (a packet larger than DEPTH that would otherwise deadlock).
  - Effect: release=1 and oversize=1 on the next edge.
  - release clears on deq of a last=1 beat; oversize stays set until reset.
- Reset mid-packet: all stored beats and partial packets are discarded; no residual last state.

Decomposition:
- Shared package (atomicc generated header set):
  - typedef pipe_beat_t #(WIDTH) {data, last}.
  - Helper constant for counter width, $clog2(DEPTH)+1.
- One sub-module, pipe_fifo_ram: DEPTH x (WIDTH+1) register array with one write port and an asynchronous read port, no reset on contents.
- The top level holds pointers, counters, release logic and handshakes.

Test Plan:
- Basic (STORE_FWD=0, DEPTH=4, WIDTH=32): enqueue 0xA1,0xA2(last) then deq both -> deq__RDY rises the cycle after the first enq; outputs 0xA1/last=0 then 0xA2/last=1; pkt_count 1 then 0.
- Store-and-forward hold (STORE_FWD=1): enqueue 0x10,0x11 without last -> deq__RDY stays 0. Enqueue 0x12(last) -> deq__RDY=1 next cycle, pkt_count=1, three beats drain in order.
- Full and wrap (DEPTH=4): write 4 single-beat packets 1..4 -> enq__RDY=0, pkt_count=4. Deq 2, enq 5,6 -> read order 3,4,5,6; pointers wrap with no loss.
- Simultaneous enq+deq at occupancy 2: occupancy stays 2. pkt_count is unchanged when both beats carry last=1.
- Oversize (STORE_FWD=1, DEPTH=4): 6-beat packet -> after 4 beats, full with pkt_count=0 -> release=1, oversize=1. All 6 beats drain. release clears after the last beat; oversize stays 1.
- Async reset: assert nRST low mid-packet with 3 beats stored -> immediately deq__RDY=0, pkt_count=0, oversize=0. After release of nRST, enq__RDY=1 and a fresh packet passes correctly.
